raw_frame_tx: RTL and testbench



---
 rtl/thinkgear_pkg.sv | 26 ++
 rtl/raw_frame_tx.sv | 182 ++++++++++++++++++
 tb/tb_raw_frame_tx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thinkgear_pkg.sv
// Shared definitions for the ThinkGear-style raw-value frame
// (AA AA 04 80 02 HI LO CS). Used by both the transmit sequencer
// and the raw-data frame parser.
package thinkgear_pkg;

  localparam logic [7:0] TG_SYNC     = 8'hAA;
  localparam logic [7:0] TG_PLEN     = 8'h04;
  localparam logic [7:0] TG_CODE_RAW = 8'h80;
  localparam logic [7:0] TG_VLEN_RAW = 8'h02;
  localparam int         TG_FRAME_LEN = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

  // One's complement of the 8-bit wrapped sum of the payload bytes.
  function automatic logic [7:0] tg_checksum(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] sum;
    sum = TG_CODE_RAW + TG_VLEN_RAW + hi + lo;
    return ~sum;
  endfunction

endpackage

// File: rtl/raw_frame_tx.sv
// raw_frame_tx: turns signed 16-bit samples into 8-byte raw-value frames
// and feeds them byte by byte to a UART transmitter via tx_start/tx_busy.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   sample_valid       one-cycle strobe qualifying sample
//   sample[15:0]       two's-complement raw value
//   tx_busy            UART transmitter shifting
//   tx_start           one-cycle pulse starting one UART byte
//   tx_data[7:0]       byte to send, held until tx_busy falls
//   frame_busy         a frame is in progress
//   frame_done         one-cycle pulse after the last byte completes
//   tx_err             sticky busy-timeout flag
//   drop_cnt[7:0]      saturating count of overwritten pending samples
module raw_frame_tx
  import thinkgear_pkg::*;
#(
  parameter logic [7:0] SYNC         = TG_SYNC,
  parameter logic [7:0] PLEN         = TG_PLEN,
  parameter logic [7:0] CODE         = TG_CODE_RAW,
  parameter logic [7:0] VLEN         = TG_VLEN_RAW,
  parameter int         BUSY_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        tx_err,
  output logic [7:0]  drop_cnt
);

  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [2:0] LAST_IDX = 3'(TG_FRAME_LEN - 1);

  tx_state_e        state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       hi_q, hi_d, lo_q, lo_d, cs_q, cs_d;
  logic [15:0]      pend_data_q, pend_data_d;
  logic             pend_vld_q, pend_vld_d;
  logic [7:0]       drop_q, drop_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             frame_busy_q, frame_busy_d;
  logic             frame_done_q, frame_done_d;
  logic             tx_err_q, tx_err_d;
  logic             load;

  function automatic logic [7:0] byte_sel(input logic [2:0] idx, input logic [7:0] hi,
                                          input logic [7:0] lo, input logic [7:0] cs);
    case (idx)
      3'd0, 3'd1: return SYNC;
      3'd2:       return PLEN;
      3'd3:       return CODE;
      3'd4:       return VLEN;
      3'd5:       return hi;
      3'd6:       return lo;
      default:    return cs;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cs_d         = cs_q;
    pend_data_d  = pend_data_q;
    pend_vld_d   = pend_vld_q;
    drop_d       = drop_q;
    tmo_d        = tmo_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    tx_err_d     = tx_err_q;
    load         = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (pend_vld_q) begin
          load    = 1'b1;
          hi_d    = pend_data_q[15:8];
          lo_d    = pend_data_q[7:0];
          cs_d    = ~(CODE + VLEN + pend_data_q[15:8] + pend_data_q[7:0]);
          idx_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        tmo_d   = '0;
        state_d = TX_WAIT_HI;
      end
      TX_WAIT_HI: begin
        // busy seen on the limit cycle still counts as success
        if (tx_busy) begin
          state_d = TX_WAIT_LO;
        end else if (tmo_q == TMO_W'(BUSY_TIMEOUT)) begin
          tx_err_d = 1'b1;
          state_d  = TX_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      TX_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = TX_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = TX_START;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // A sample arriving in the load cycle replaces an entry that is leaving,
    // so it is not a drop.
    if (sample_valid) begin
      pend_data_d = sample;
      pend_vld_d  = 1'b1;
      if (pend_vld_q && !load && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (load) begin
      pend_vld_d = 1'b0;
    end

    // Outputs are registered, so decode from the next state.
    if (state_d == TX_START) begin
      tx_start_d = 1'b1;
      tx_data_d  = byte_sel(idx_d, hi_d, lo_d, cs_d);
    end
    frame_busy_d = (state_d != TX_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= TX_IDLE;
      idx_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      cs_q         <= '0;
      pend_data_q  <= '0;
      pend_vld_q   <= 1'b0;
      drop_q       <= '0;
      tmo_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cs_q         <= cs_d;
      pend_data_q  <= pend_data_d;
      pend_vld_q   <= pend_vld_d;
      drop_q       <= drop_d;
      tmo_q        <= tmo_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      tx_err_q     <= tx_err_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;
  assign tx_err     = tx_err_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_raw_frame_tx.sv
module tb_raw_frame_tx;

  localparam int BUSY_TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic        frame_done;
  logic        tx_err;
  logic [7:0]  drop_cnt;

  raw_frame_tx #(.BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .frame_busy(frame_busy), .frame_done(frame_done), .tx_err(tx_err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // UART model state
  logic [7:0] rx_q[$];
  int  cur_dly = 2;
  int  cur_len = 20;
  bit  uart_dead = 1'b0;
  int  done_cnt = 0;
  int  hold_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference frame built straight from the frame layout rules.
  function automatic logic [63:0] ref_frame(input logic [15:0] s);
    int hi, lo, cs;
    hi = s / 256;
    lo = s % 256;
    cs = 255 - ((128 + 2 + hi + lo) % 256);
    return {8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'(hi), 8'(lo), 8'(cs)};
  endfunction

  // UART transmitter model plus byte collector; runs at negedge.
  initial begin
    int phase, dly, blen;
    logic [7:0] hold;
    bit bad;
    phase = 0; dly = 0; blen = 0; hold = '0; bad = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        tx_busy = 1'b0;
        phase = 0;
      end else begin
        if (tx_start) begin
          rx_q.push_back(tx_data);
          hold = tx_data;
          bad = 0;
          if (!uart_dead) begin
            dly = cur_dly;
            phase = 1;
          end
        end else if (phase == 1) begin
          if (dly <= 1) begin
            tx_busy = 1'b1;
            blen = cur_len;
            phase = 2;
          end else dly--;
        end else if (phase == 2) begin
          if (tx_data !== hold) bad = 1;
          if (blen <= 1) begin
            tx_busy = 1'b0;
            phase = 0;
            if (bad) hold_bad++;
          end else blen--;
        end
        if (frame_done) done_cnt++;
      end
    end
  end

  task automatic send(input logic [15:0] s);
    @(negedge clk);
    sample = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_frame(input logic [15:0] s);
    logic [63:0] exp;
    exp = ref_frame(s);
    wait_bytes(8, 1000);
    if (rx_q.size() < 8) begin
      chk("frame_wait", rx_q.size(), 8);
      rx_q.delete();
    end else begin
      for (int i = 0; i < 8; i++)
        chk($sformatf("s%04h_byte%0d", s, i), rx_q.pop_front(), exp[8*(7-i) +: 8]);
    end
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 20000 && quiet < 4; i++) begin
      @(posedge clk); #1;
      quiet = frame_busy ? 0 : quiet + 1;
    end
    chk("idle_wait", frame_busy, 1'b0);
  endtask

  initial begin
    logic [15:0] dir[4];
    logic [63:0] exp;
    logic [7:0]  b[8];
    int d0, n, sum;
    logic [15:0] s;

    dir[0] = 16'h0102; dir[1] = 16'hFFFF; dir[2] = 16'h8000; dir[3] = 16'h0000;
    rst = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    #1;
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_frame_busy", frame_busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_tx_err", tx_err, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Directed frames, including the sign/boundary values.
    for (int k = 0; k < 4; k++) begin
      d0 = done_cnt;
      send(dir[k]);
      check_frame(dir[k]);
      wait_idle();
      chk("frame_done_once", done_cnt - d0, 1);
    end

    // Start latency: valid at N, tx_start at N+2.
    @(negedge clk);
    sample = 16'h1234;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    chk("lat_n1_start", tx_start, 1'b0);
    @(posedge clk); #1;
    chk("lat_n2_start", tx_start, 1'b1);
    chk("lat_n2_data", tx_data, 8'hAA);
    check_frame(16'h1234);
    wait_idle();

    // New sample in the load cycle: both sent, no drop.
    @(negedge clk);
    sample = 16'h0A0B; sample_valid = 1'b1;
    @(negedge clk);
    sample = 16'h0C0D;
    @(negedge clk);
    sample_valid = 1'b0;
    check_frame(16'h0A0B);
    check_frame(16'h0C0D);
    wait_idle();
    chk("simul_drop", drop_cnt, 8'd0);

    // Overrun: three samples during one frame, latest wins.
    send(16'h5555);
    wait_bytes(1, 100);
    send(16'h0011);
    send(16'h0022);
    send(16'h0033);
    chk("overrun_drop", drop_cnt, 8'd2);
    check_frame(16'h5555);
    check_frame(16'h0033);
    wait_idle();
    chk("overrun_drop_after", drop_cnt, 8'd2);
    chk("hold_stable", hold_bad, 0);

    // Flood: drop counter saturates; last sample is the final frame.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      sample = 16'(16'h0100 + k);
      sample_valid = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    wait_idle();
    chk("flood_drop_sat", drop_cnt, 8'd255);
    chk("flood_whole_frames", rx_q.size() % 8, 0);
    if (rx_q.size() >= 8) begin
      exp = ref_frame(16'h0100 + 16'd299);
      for (int i = 0; i < 8; i++)
        chk($sformatf("flood_last_byte%0d", i), rx_q[rx_q.size() - 8 + i], exp[8*(7-i) +: 8]);
    end
    rx_q.delete();

    // Busy timeout with a silent UART.
    uart_dead = 1'b1;
    d0 = done_cnt;
    send(16'h7777);
    wait_bytes(1, 100);
    n = 0;
    for (int i = 0; i < 1200 && !tx_err; i++) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_err", tx_err, 1'b1);
    chk("tmo_latency_ok", (n >= BUSY_TIMEOUT && n <= BUSY_TIMEOUT + 2), 1'b1);
    @(posedge clk); #1;
    chk("tmo_idle", frame_busy, 1'b0);
    chk("tmo_no_done", done_cnt - d0, 0);
    chk("tmo_one_byte", rx_q.size(), 1);
    rx_q.delete();
    uart_dead = 1'b0;
    send(16'h2468);
    check_frame(16'h2468);
    wait_idle();
    chk("tmo_err_sticky", tx_err, 1'b1);

    // Reset during byte 4.
    send(16'h4321);
    wait_bytes(5, 400);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx_start", tx_start, 1'b0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_frame_busy", frame_busy, 1'b0);
    chk("mid_rst_frame_done", frame_done, 1'b0);
    chk("mid_rst_tx_err", tx_err, 1'b0);
    chk("mid_rst_drop_cnt", drop_cnt, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rx_q.delete();
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_no_start", rx_q.size(), 0);

    // Random loopback through a frame parser.
    for (int k = 0; k < 100; k++) begin
      cur_dly = $urandom_range(1, 3);
      cur_len = $urandom_range(1, 8);
      s = 16'($urandom);
      send(s);
      wait_bytes(8, 1000);
      if (rx_q.size() < 8) begin
        chk("lb_wait", rx_q.size(), 8);
        rx_q.delete();
      end else begin
        for (int i = 0; i < 8; i++) b[i] = rx_q.pop_front();
        sum = (b[3] + b[4] + b[5] + b[6] + b[7]) % 256;
        chk("lb_header_cs", (b[0] == 8'hAA && b[1] == 8'hAA && b[2] == 8'h04 &&
                             b[3] == 8'h80 && b[4] == 8'h02 && sum == 255), 1'b1);
        chk("lb_value", {b[5], b[6]}, s);
      end
      wait_idle();
    end
    chk("lb_drop", drop_cnt, 8'd0);
    chk("lb_hold_stable", hold_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
